fetch_unit: RTL

Instruction-fetch stage that owns the architectural program counter, directly upstream of the next-PC logic and the decoder. It issues one instruction-memory read per instruction over a req/ack handshake, holds the returned word for the decode stage under a valid/ready handshake, and loads the externally computed next PC when decode accepts the instruction. It also counts accepted instructions.

---
 rtl/fetch_if.sv | 23 ++
 rtl/fetch_unit.sv | 90 +++++++++
 2 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory read channel, decode hand-off and PC export.
interface fetch_if;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] instr_count;

  modport master (
    output pc, imem_req, imem_addr, id_valid, id_instr, instr_count,
    input  npc, imem_ack, imem_rdata, id_ready
  );

  modport slave (
    input  pc, imem_req, imem_addr, id_valid, id_instr, instr_count,
    output npc, imem_ack, imem_rdata, id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one imem read per instruction and holds
// the word for decode until accepted. All outputs come straight from flops.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic    clk,
  input logic    rst_n,
  fetch_if.master f
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        vld_q, vld_d;

  // Low npc bits are dropped: the PC is always word-aligned.
  logic npc_lo_unused;
  assign npc_lo_unused = ^f.npc[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
      end
      REQ: begin
        if (f.imem_ack) begin
          instr_d = f.imem_rdata;
          state_d = HOLD;
          req_d   = 1'b0;
          vld_d   = 1'b1;
        end
      end
      HOLD: begin
        if (f.id_ready) begin
          pc_d    = {f.npc[31:2], 2'b00};
          cnt_d   = cnt_q + 32'd1;
          state_d = REQ;
          req_d   = 1'b1;
          vld_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      cnt_q   <= 32'd0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      vld_q   <= vld_d;
    end
  end

  assign f.pc          = pc_q;
  assign f.imem_addr   = pc_q;
  assign f.imem_req    = req_q;
  assign f.id_valid    = vld_q;
  assign f.id_instr    = instr_q;
  assign f.instr_count = cnt_q;

endmodule
